// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures incoming hsync/vsync, locks onto the
// expected raster and reconstructs pixel coordinates and display enable.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_PW        = 96,
    parameter int H_BP        = 48,
    parameter int H_DISP      = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_PW        = 2,
    parameter int V_BP        = 33,
    parameter int V_DISP      = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        locked,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        frame_start,
    output logic        err_hlen,
    output logic        err_hpw,
    output logic        err_vlen
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] H_PWL   = 11'(H_PW);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] H_OFS   = 11'(H_PW + H_BP);
    localparam logic [10:0] H_END   = 11'(H_PW + H_BP + H_DISP);
    localparam logic [10:0] V_OFS   = 11'(V_PW + V_BP);
    localparam logic [10:0] V_END   = 11'(V_PW + V_BP + V_DISP);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    state_t      state, state_n;
    logic [7:0]  good, good_n;
    logic        hs_s1, hs_s2, vs_s1, vs_s2;
    logic        hfall, hrise, vfall;
    logic        vpend;
    logic [10:0] h_cnt, v_cnt, hpw_cnt;
    logic [10:0] h_next, v_next;
    logic        checks_on, boundary;
    logic        hlen_bad, hpw_bad, vlen_bad, err_now, err_q;

    // Edge strobes are registered, so hfall is seen one cycle after the first
    // low sample in s1 and all counters act on that registered strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1 <= 1'b1;
            hs_s2 <= 1'b1;
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            hfall <= 1'b0;
            hrise <= 1'b0;
            vfall <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            hs_s1 <= hsync_in;
            hs_s2 <= hs_s1;
            vs_s1 <= vsync_in;
            vs_s2 <= vs_s1;
            hfall <= hs_s2 & ~hs_s1;
            hrise <= ~hs_s2 & hs_s1;
            vfall <= vs_s2 & ~vs_s1;
        end
    end

    assign h_next    = h_cnt + 11'd1;
    assign v_next    = v_cnt + 11'd1;
    assign checks_on = (state != SEARCH);
    assign boundary  = hfall & (vpend | vfall);

    // Watchdog fires on the step into saturation, so a stuck hsync pulses once.
    assign hlen_bad = checks_on & ((hfall & (h_next != H_TOT)) |
                                   (~hfall & (h_cnt == CNT_MAX - 11'd1)));
    assign hpw_bad  = checks_on & hrise & (hpw_cnt != H_PWL);
    assign vlen_bad = checks_on & boundary & (v_next != V_TOT);
    assign err_now  = hlen_bad | hpw_bad | vlen_bad;
    assign err_q    = err_hlen | err_hpw | err_vlen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hpw_cnt     <= '0;
            vpend       <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (hfall) begin
                line_len <= h_next;
                h_cnt    <= '0;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_next;
            end

            if (hfall) begin
                hpw_cnt <= 11'd1;
            end else if (!hs_s2 && hpw_cnt != CNT_MAX) begin
                hpw_cnt <= hpw_cnt + 11'd1;
            end

            if (boundary) begin
                frame_lines <= v_next;
                v_cnt       <= '0;
                vpend       <= 1'b0;
            end else begin
                if (vfall) begin
                    vpend <= 1'b1;
                end
                if (hfall && v_cnt != CNT_MAX) begin
                    v_cnt <= v_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_hlen    <= 1'b0;
            err_hpw     <= 1'b0;
            err_vlen    <= 1'b0;
            frame_start <= 1'b0;
            state       <= SEARCH;
            good        <= '0;
        end else begin
            err_hlen    <= hlen_bad;
            err_hpw     <= hpw_bad;
            err_vlen    <= vlen_bad;
            frame_start <= boundary;
            state       <= state_n;
            good        <= good_n;
        end
    end

    // A registered error pulse drops the lock one cycle later; an error seen in
    // the boundary cycle itself blocks the good-frame count.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_n = state;
        good_n  = good;
        unique case (state)
            SEARCH: begin
                if (boundary) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (err_q) begin
                    state_n = SEARCH;
                end else if (boundary && !err_now) begin
                    good_n = good + 8'd1;
                    if (good_n == LOCK_N) begin
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err_q) begin
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);
    assign x      = locked ? (h_cnt - H_OFS) : '0;
    assign y      = locked ? (v_cnt - V_OFS) : '0;
    assign de     = locked && (h_cnt >= H_OFS) && (h_cnt < H_END) &&
                    (v_cnt >= V_OFS) && (v_cnt < V_END);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomized bench for vga_timing_monitor on a shrunken raster: a sync source
// with injectable faults, and a position-delay model for coordinate checks.
module tb_vga_timing_monitor;

    localparam int HT = 80, HPW = 8, HBP = 6, HD = 60;
    localparam int VT = 20, VPW = 2, VBP = 3, VD = 12;
    localparam int LF = 2;
    localparam int HO = HPW + HBP;
    localparam int VO = VPW + VBP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync_in, vsync_in;
    logic        locked, de, frame_start, err_hlen, err_hpw, err_vlen;
    logic [10:0] x, y, line_len, frame_lines;

    int n_checks = 0;
    int n_pass   = 0;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_PW(HPW), .H_BP(HBP), .H_DISP(HD),
        .V_TOTAL(VT), .V_PW(VPW), .V_BP(VBP), .V_DISP(VD),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .locked(locked), .x(x), .y(y), .de(de),
        .line_len(line_len), .frame_lines(frame_lines), .frame_start(frame_start),
        .err_hlen(err_hlen), .err_hpw(err_hpw), .err_vlen(err_vlen)
    );

    always #5 clk = ~clk;

    // Event log sampled on the falling edge.
    int cyc = 0, n_fs = 0, n_hlen = 0, n_hpw = 0, n_vlen = 0;
    int hlen_cyc = 0, hpw_cyc = 0, vlen_cyc = 0, fall_cyc = 0;
    int lock_fs = 0, fall_fs = 0;
    logic [10:0] ll_at_err = '0, fl_at_err = '0;
    logic lk_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_start === 1'b1) n_fs = n_fs + 1;
        if (err_hlen === 1'b1) begin n_hlen = n_hlen + 1; hlen_cyc = cyc; ll_at_err = line_len; end
        if (err_hpw === 1'b1) begin n_hpw = n_hpw + 1; hpw_cyc = cyc; end
        if (err_vlen === 1'b1) begin n_vlen = n_vlen + 1; vlen_cyc = cyc; fl_at_err = frame_lines; end
        if (locked === 1'b1 && !lk_prev) lock_fs = n_fs;
        if (locked !== 1'b1 && lk_prev) begin fall_fs = n_fs; fall_cyc = cyc; end
        lk_prev = (locked === 1'b1);
    end

    // Source position history: the monitor's counters trail the sample edge by two.
    int h0 = 0, h1 = 0, h2 = 0, v0 = 0, v1 = 0, v2 = 0;
    bit c0 = 0, c1 = 0, c2 = 0;
    int line_c0 = 0;

    task automatic drive_cycle(input logic hs, input logic vs, input int hp, input int vp,
                               input bit chk);
        logic [10:0] ex, ey;
        logic        ede;
        bit          pick;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
        h2 = h1; h1 = h0; h0 = hp;
        v2 = v1; v1 = v0; v0 = vp;
        c2 = c1; c1 = c0; c0 = chk;
        if (hp == 0) line_c0 = cyc;
        pick = ((h2 == HO-1 || h2 == HO || h2 == HO+HD-1 || h2 == HO+HD) &&
                (v2 == VO-1 || v2 == VO || v2 == VO+VD-1 || v2 == VO+VD)) ||
               ($urandom_range(0, 63) == 0);
        if (c2 && pick) begin
            ex  = 11'((h2 - HO + 2048) % 2048);
            ey  = 11'((v2 - VO + 2048) % 2048);
            ede = (h2 >= HO) && (h2 < HO + HD) && (v2 >= VO) && (v2 < VO + VD);
            n_checks++;
            if ({locked, x, y, de} !== {1'b1, ex, ey, ede})
                $display("FAIL coords h=%0d v=%0d: got locked=%0b x=%0d y=%0d de=%0b, expected 1 x=%0d y=%0d de=%0b",
                         h2, v2, locked, x, y, de, ex, ey, ede);
            else n_pass++;
        end
    endtask

    task automatic drive_frame(input int lines, input int bad_line, input int bad_len,
                               input int bad_pw, input bit chk);
        int len, pw;
        for (int v = 0; v < lines; v++) begin
            len = (v == bad_line) ? bad_len : HT;
            pw  = (v == bad_line) ? bad_pw  : HPW;
            for (int h = 0; h < len; h++)
                drive_cycle((h < pw) ? 1'b0 : 1'b1, (v < VPW) ? 1'b0 : 1'b1, h, v, chk);
        end
    endtask

    task automatic relock(input int nframes);
        for (int f = 0; f < nframes - 1; f++) drive_frame(VT, -1, HT, HPW, 0);
        drive_frame(VT, -1, HT, HPW, 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, de, frame_start, err_hlen, err_hpw, err_vlen} !== 6'b0)
            $display("FAIL reset_flags: got %b, expected 000000",
                     {locked, de, frame_start, err_hlen, err_hpw, err_vlen});
        else n_pass++;
        n_checks++;
        if ({x, y} !== 22'b0) $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", x, y);
        else n_pass++;
        n_checks++;
        if ({line_len, frame_lines} !== 22'b0)
            $display("FAIL reset_meas: got line_len=%0d frame_lines=%0d, expected 0 0", line_len, frame_lines);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) drive_cycle(1'b1, 1'b1, 0, 0, 0);
    endtask

    task automatic test_lock();
        int bfs, berr;
        bfs  = n_fs;
        berr = n_hlen + n_hpw + n_vlen;
        drive_frame(VT, -1, HT, HPW, 0);
        drive_frame(VT, -1, HT, HPW, 0);
        drive_frame(VT, -1, HT, HPW, 1);
        n_checks++;
        if (lock_fs - bfs !== 3) $display("FAIL lock_boundary: got %0d, expected 3", lock_fs - bfs);
        else n_pass++;
        n_checks++;
        if (n_fs - bfs !== 3) $display("FAIL frame_start_count: got %0d, expected 3", n_fs - bfs);
        else n_pass++;
        n_checks++;
        if (n_hlen + n_hpw + n_vlen - berr !== 0)
            $display("FAIL lock_no_errors: got %0d pulses, expected 0", n_hlen + n_hpw + n_vlen - berr);
        else n_pass++;
        n_checks++;
        if ({locked, line_len, frame_lines} !== {1'b1, 11'(HT), 11'(VT)})
            $display("FAIL lock_meas: got locked=%0b line_len=%0d frame_lines=%0d, expected 1 %0d %0d",
                     locked, line_len, frame_lines, HT, VT);
        else n_pass++;
    endtask

    task automatic test_hlen();
        int bl, len, bh, bo;
        bl  = $urandom_range(3, VT - 3);
        len = ($urandom_range(0, 1) == 1) ? HT + $urandom_range(1, 3) : HT - $urandom_range(1, 3);
        bh  = n_hlen;
        bo  = n_hpw + n_vlen;
        drive_frame(VT, bl, len, HPW, 0);
        relock(3);
        n_checks++;
        if (n_hlen - bh !== 1) $display("FAIL hlen_pulses: got %0d, expected 1 (len %0d)", n_hlen - bh, len);
        else n_pass++;
        n_checks++;
        if (n_hpw + n_vlen - bo !== 0) $display("FAIL hlen_other_errs: got %0d, expected 0", n_hpw + n_vlen - bo);
        else n_pass++;
        n_checks++;
        if (ll_at_err !== 11'(len)) $display("FAIL hlen_line_len: got %0d, expected %0d", ll_at_err, len);
        else n_pass++;
        n_checks++;
        if (fall_cyc !== hlen_cyc + 1) $display("FAIL hlen_unlock: got cycle %0d, expected %0d", fall_cyc, hlen_cyc + 1);
        else n_pass++;
        n_checks++;
        if (lock_fs - fall_fs !== 3 || locked !== 1'b1)
            $display("FAIL hlen_relock: got %0d boundaries locked=%0b, expected 3 and 1", lock_fs - fall_fs, locked);
        else n_pass++;
    endtask

    task automatic test_hpw();
        int bl, pw, bp, bo;
        bl = $urandom_range(3, VT - 3);
        pw = ($urandom_range(0, 1) == 1) ? HPW + $urandom_range(1, 3) : HPW - $urandom_range(1, 3);
        bp = n_hpw;
        bo = n_hlen + n_vlen;
        drive_frame(VT, bl, HT, pw, 0);
        relock(3);
        n_checks++;
        if (n_hpw - bp !== 1) $display("FAIL hpw_pulses: got %0d, expected 1 (pw %0d)", n_hpw - bp, pw);
        else n_pass++;
        n_checks++;
        if (n_hlen + n_vlen - bo !== 0) $display("FAIL hpw_other_errs: got %0d, expected 0", n_hlen + n_vlen - bo);
        else n_pass++;
        n_checks++;
        if (fall_cyc !== hpw_cyc + 1) $display("FAIL hpw_unlock: got cycle %0d, expected %0d", fall_cyc, hpw_cyc + 1);
        else n_pass++;
        n_checks++;
        if (lock_fs - fall_fs !== 3 || line_len !== 11'(HT))
            $display("FAIL hpw_relock: got %0d boundaries line_len=%0d, expected 3 and %0d",
                     lock_fs - fall_fs, line_len, HT);
        else n_pass++;
    endtask

    task automatic test_vlen();
        int lines, bv, bo;
        lines = ($urandom_range(0, 1) == 1) ? VT + $urandom_range(1, 2) : VT - $urandom_range(1, 2);
        bv = n_vlen;
        bo = n_hlen + n_hpw;
        drive_frame(lines, -1, HT, HPW, 0);
        relock(4);
        n_checks++;
        if (n_vlen - bv !== 1) $display("FAIL vlen_pulses: got %0d, expected 1 (lines %0d)", n_vlen - bv, lines);
        else n_pass++;
        n_checks++;
        if (n_hlen + n_hpw - bo !== 0) $display("FAIL vlen_other_errs: got %0d, expected 0", n_hlen + n_hpw - bo);
        else n_pass++;
        n_checks++;
        if (fl_at_err !== 11'(lines)) $display("FAIL vlen_frame_lines: got %0d, expected %0d", fl_at_err, lines);
        else n_pass++;
        n_checks++;
        if (fall_cyc !== vlen_cyc + 1 || lock_fs - fall_fs !== 3)
            $display("FAIL vlen_relock: got fall %0d boundaries %0d, expected %0d and 3",
                     fall_cyc, lock_fs - fall_fs, vlen_cyc + 1);
        else n_pass++;
        n_checks++;
        if (frame_lines !== 11'(VT)) $display("FAIL vlen_recover: got %0d, expected %0d", frame_lines, VT);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int nl, np;
        nl = $urandom_range(3, 8);
        np = $urandom_range(20, 60);
        drive_frame(nl, -1, HT, HPW, 1);
        for (int h = 0; h < np; h++) drive_cycle((h < HPW) ? 1'b0 : 1'b1, 1'b1, h, nl, 1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({locked, de, frame_start, err_hlen, err_hpw, err_vlen} !== 6'b0)
            $display("FAIL midline_flags: got %b, expected 000000",
                     {locked, de, frame_start, err_hlen, err_hpw, err_vlen});
        else n_pass++;
        n_checks++;
        if ({x, y, line_len, frame_lines} !== 44'b0)
            $display("FAIL midline_values: got x=%0d y=%0d line_len=%0d frame_lines=%0d, expected all 0",
                     x, y, line_len, frame_lines);
        else n_pass++;
        c0 = 0; c1 = 0; c2 = 0;
        repeat (3) drive_cycle(1'b1, 1'b1, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) drive_cycle(1'b1, 1'b1, 0, 0, 0);
    endtask

    task automatic test_stuck();
        int nl, bh, bo, start_c;
        nl = $urandom_range(4, 10);
        bh = n_hlen;
        bo = n_hpw + n_vlen;
        drive_frame(nl, -1, HT, HPW, 1);
        start_c = line_c0;
        repeat (2200) drive_cycle(1'b1, 1'b1, 0, 0, 0);
        n_checks++;
        if (n_hlen - bh !== 1) $display("FAIL stuck_pulses: got %0d, expected 1", n_hlen - bh);
        else n_pass++;
        n_checks++;
        if (hlen_cyc !== start_c + 2050)
            $display("FAIL stuck_watchdog_time: got cycle %0d, expected %0d", hlen_cyc, start_c + 2050);
        else n_pass++;
        n_checks++;
        if (n_hpw + n_vlen - bo !== 0) $display("FAIL stuck_other_errs: got %0d, expected 0", n_hpw + n_vlen - bo);
        else n_pass++;
        n_checks++;
        if (fall_cyc !== hlen_cyc + 1) $display("FAIL stuck_unlock: got cycle %0d, expected %0d", fall_cyc, hlen_cyc + 1);
        else n_pass++;
        n_checks++;
        if ({locked, x, y, de} !== 24'b0)
            $display("FAIL stuck_outputs: got locked=%0b x=%0d y=%0d de=%0b, expected all 0", locked, x, y, de);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hlen();
        test_hlen();
        test_hpw();
        test_hpw();
        test_vlen();
        test_reset_midline();
        test_lock();
        test_stuck();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
